// File: rtl/dvp_capture_ctrl_pkg.sv
// dvp_capture_ctrl_pkg: shared capture state, mode and status types for the DVP capture controller.
package dvp_capture_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE} cap_state_t;
  typedef enum logic {SINGLE, CONT} cap_mode_t;
  localparam int STAT_FCNT_W = 16;
  typedef struct packed {
    logic                   busy;
    logic                   err_short;
    logic                   err_long;
    logic                   overflow;
    logic [STAT_FCNT_W-1:0] frame_cnt;
  } cap_status_t;
endpackage

// File: rtl/dvp_capture_ctrl_pix_raster_cnt.sv
// pix_raster_cnt: horizontal/vertical pixel position within a frame, with first/eol/last decodes.
module pix_raster_cnt #(
  parameter int WIDTH = 1280,
  parameter int HEIGHT = 720,
  localparam int HW = WIDTH > 1 ? $clog2(WIDTH) : 1,
  localparam int VW = HEIGHT > 1 ? $clog2(HEIGHT) : 1
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          first,
  output logic          eol,
  output logic          last
);
  assign first = (hcnt == '0) & (vcnt == '0);
  assign eol   = hcnt == HW'(WIDTH - 1);
  assign last  = eol & (vcnt == VW'(HEIGHT - 1));
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (clr) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (adv) begin
      hcnt <= eol ? '0 : hcnt + 1'b1;
      if (eol) vcnt <= last ? '0 : vcnt + 1'b1;
    end
  end
endmodule

// File: rtl/dvp_capture_ctrl.sv
// dvp_capture_ctrl: frame-aligned capture gate for the DVP pixel stream with SOF/EOL/EOF framing,
// frame counting and sticky short/long/overflow error flags.
module dvp_capture_ctrl
  import dvp_capture_ctrl_pkg::*;
#(
  parameter int WIDTH = 1280,
  parameter int HEIGHT = 720,
  parameter int DATA_W = 24,
  parameter int FCNT_W = 16
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic              cmd_cont,
  input  logic              cmd_stop,
  input  logic              clr_err,
  input  logic              vsync,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ds_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err_short,
  output logic              err_long,
  output logic              overflow
);
  localparam int HW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int VW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  cap_state_t state, state_n;
  cap_mode_t mode;
  logic vsync_d, stop_pending, post_eof;
  logic first, eol, r_last;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic cap, pix, last, vs_rise, clr_cnt, unused;
  assign vs_rise = vsync & ~vsync_d;
  assign cap     = state == CAPTURE;
  assign pix     = cap & in_valid;
  assign last    = pix & r_last;
  // a vsync that lands before the last pixel restarts the raster for the new frame
  assign clr_cnt = vs_rise & ((state == ARM) | (cap & ~last));
  assign busy    = state != IDLE;
  assign unused  = ^{hcnt, vcnt};
  pix_raster_cnt #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_raster (
    .pclk (pclk),
    .rst_n(rst_n),
    .clr  (clr_cnt),
    .adv  (pix),
    .hcnt (hcnt),
    .vcnt (vcnt),
    .first(first),
    .eol  (eol),
    .last (r_last)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_start & ~cmd_stop) state_n = ARM;
      ARM:     state_n = cmd_stop ? IDLE : vs_rise ? CAPTURE : ARM;
      CAPTURE: if (last) state_n = (mode == SINGLE | stop_pending | cmd_stop) ? IDLE : ARM;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d      <= 1'b0;
      mode         <= SINGLE;
      stop_pending <= 1'b0;
      post_eof     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sof      <= 1'b0;
      out_eol      <= 1'b0;
      out_eof      <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      vsync_d <= vsync;
      if (state == IDLE & cmd_start & ~cmd_stop) mode <= cmd_cont ? CONT : SINGLE;
      stop_pending <= (state_n == IDLE) ? 1'b0 : stop_pending | (cap & cmd_stop);
      post_eof     <= (state_n == IDLE | vs_rise) ? 1'b0 : post_eof | last;
      out_valid    <= pix & ds_ready;
      if (in_valid) out_data <= in_data;
      out_sof      <= pix & ds_ready & first;
      out_eol      <= pix & ds_ready & eol;
      out_eof      <= last & ds_ready;
      // a dropped EOF pixel still closes the frame
      frame_done   <= last;
      frame_cnt    <= frame_cnt + FCNT_W'(last);
      err_short    <= (cap & vs_rise & ~last) | (err_short & ~clr_err);
      err_long     <= (state == ARM & in_valid & post_eof) | (err_long & ~clr_err);
      overflow     <= (pix & ~ds_ready) | (overflow & ~clr_err);
    end
  end
endmodule
